gf32_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared gf_mul_32 or gf251_mul_32 instance. It serves N_REQ requesters, for example party_computation and evaluate.
- It replaces the ad-hoc combinational start/operand muxing at the top level. Each requester keeps its own start/done handshake, and exactly one operation is in flight at a time.
- It sits between the requesters and the shared 32-bit multiplier in the sign datapath.

---
 rtl/gf32_mul_arbiter.sv | 178 +++++++++++++++++
 tb/tb_gf32_mul_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf32_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit GF multiplier among N_REQ requesters.
// One operation in flight at a time; each requester keeps its own start/done handshake.
module gf32_mul_arbiter #(
    parameter int N_REQ        = 2,
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_start,
    input  logic [N_REQ*WIDTH-1:0] i_x,
    input  logic [N_REQ*WIDTH-1:0] i_y,
    output logic [WIDTH-1:0]       o_o,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_busy,
    output logic                   o_err,
    output logic                   o_mul_start,
    output logic [WIDTH-1:0]       o_mul_x,
    output logic [WIDTH-1:0]       o_mul_y,
    input  logic [WIDTH-1:0]       i_mul_o,
    input  logic                   i_mul_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic [N_REQ-1:0]   pending_reg, pending_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [PTR_W-1:0]   owner_reg, owner_next;
    logic               mul_start_reg, mul_start_next;
    logic [WIDTH-1:0]   mul_x_reg, mul_x_next;
    logic [WIDTH-1:0]   mul_y_reg, mul_y_next;
    logic [WIDTH-1:0]   o_reg, o_next;
    logic [N_REQ-1:0]   done_reg, done_next;
    logic               err_reg, err_next;

    logic [N_REQ-1:0]   accept_vec;
    logic [N_REQ-1:0]   dup_vec;
    logic [N_REQ-1:0]   clear_vec;
    logic [WIDTH-1:0]   lat_x [N_REQ];
    logic [WIDTH-1:0]   lat_y [N_REQ];
    logic [PTR_W-1:0]   winner;
    logic               win_found;
    logic [PTR_W:0]     cand;

    // Per-requester operand latches; only written when the requester is free.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [WIDTH-1:0] x_reg;
            logic [WIDTH-1:0] y_reg;

            assign accept_vec[gi] = i_start[gi] & ~pending_reg[gi];
            assign dup_vec[gi]    = i_start[gi] &  pending_reg[gi];
            assign lat_x[gi]      = x_reg;
            assign lat_y[gi]      = y_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    x_reg <= '0;
                    y_reg <= '0;
                end else if (accept_vec[gi]) begin
                    x_reg <= i_x[WIDTH*gi +: WIDTH];
                    y_reg <= i_y[WIDTH*gi +: WIDTH];
                end
            end
        end
    endgenerate

    // First pending index at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_reg} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (!win_found && pending_reg[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                winner    = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        mul_start_next = 1'b0;
        mul_x_next     = mul_x_reg;
        mul_y_next     = mul_y_reg;
        o_next         = o_reg;
        done_next      = '0;
        clear_vec      = '0;
        err_next       = err_reg | (|dup_vec);

        case (state_reg)
            ST_FLUSH: begin
                if (flush_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 1'b1;
                end
            end
            ST_IDLE: begin
                if (win_found) begin
                    mul_x_next     = lat_x[winner];
                    mul_y_next     = lat_y[winner];
                    mul_start_next = 1'b1;
                    owner_next     = winner;
                    state_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mul_done) begin
                    o_next               = i_mul_o;
                    done_next[owner_reg] = 1'b1;
                    clear_vec[owner_reg] = 1'b1;
                    ptr_next             = (owner_reg == PTR_W'(N_REQ-1)) ? '0 : owner_reg + 1'b1;
                    state_next           = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_FLUSH;
            end
        endcase

        // A requester being cleared was pending, so it cannot also be accepted.
        pending_next = (pending_reg & ~clear_vec) | accept_vec;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= CNT_W'(FLUSH_CYCLES-1);
            pending_reg   <= '0;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            mul_start_reg <= 1'b0;
            mul_x_reg     <= '0;
            mul_y_reg     <= '0;
            o_reg         <= '0;
            done_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            pending_reg   <= pending_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            mul_start_reg <= mul_start_next;
            mul_x_reg     <= mul_x_next;
            mul_y_reg     <= mul_y_next;
            o_reg         <= o_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
        end
    end

    assign o_o         = o_reg;
    assign o_done      = done_reg;
    assign o_err       = err_reg;
    assign o_mul_start = mul_start_reg;
    assign o_mul_x     = mul_x_reg;
    assign o_mul_y     = mul_y_reg;
    assign o_busy      = (|pending_reg) | (state_reg == ST_WAIT);

endmodule

// File: tb/tb_gf32_mul_arbiter.sv
// Bench for gf32_mul_arbiter: directed test-plan steps plus random traffic, checked
// against a request-level model (pending set, pointer, in-flight op) and a multiplier stand-in.
module tb_gf32_mul_arbiter;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int FL = 8;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_start;
    logic [N*W-1:0] i_x;
    logic [N*W-1:0] i_y;
    logic [W-1:0]   o_o;
    logic [N-1:0]   o_done;
    logic           o_busy;
    logic           o_err;
    logic           o_mul_start;
    logic [W-1:0]   o_mul_x;
    logic [W-1:0]   o_mul_y;
    logic [W-1:0]   i_mul_o    = '0;
    logic           i_mul_done = 1'b0;

    always #5 i_clk = ~i_clk;

    gf32_mul_arbiter #(.N_REQ(N), .WIDTH(W), .FLUSH_CYCLES(FL)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_x(i_x), .i_y(i_y),
        .o_o(o_o), .o_done(o_done), .o_busy(o_busy), .o_err(o_err),
        .o_mul_start(o_mul_start), .o_mul_x(o_mul_x), .o_mul_y(o_mul_y),
        .i_mul_o(i_mul_o), .i_mul_done(i_mul_done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        return a * b;
    endfunction

    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference model state
    logic [N-1:0] m_pend = '0;
    logic [W-1:0] m_x [N];
    logic [W-1:0] m_y [N];
    int           m_ptr = 0;
    logic         m_err = 1'b0;
    bit           inflight = 0;
    int           owner = 0;
    logic [W-1:0] exp_gx, exp_gy;
    int           s_cnt = 0;
    int           mul_lat = 3;
    int           mcnt = 0;
    logic [W-1:0] mres = '0;

    initial begin : monitor
        logic           done_s, rst_s;
        logic [N-1:0]   st_s, p0;
        logic [N*W-1:0] x_s, y_s;
        bit             exp_grant, exp_done;
        int             w;
        forever begin
            @(posedge i_clk);
            done_s = i_mul_done; rst_s = i_rst; st_s = i_start; x_s = i_x; y_s = i_y;
            #1;
            if (rst_s) begin
                m_pend = '0; m_ptr = 0; m_err = 1'b0; inflight = 0; s_cnt = 0;
                check("rst_done", 64'(o_done), 0);
                check("rst_mul_start", 64'(o_mul_start), 0);
                check("rst_busy", 64'(o_busy), 0);
                check("rst_err", 64'(o_err), 0);
                check("rst_o", 64'(o_o), 0);
                check("rst_mul_x", 64'(o_mul_x), 0);
            end else begin
                if (s_cnt < 1000) s_cnt++;
                p0        = m_pend;
                exp_grant = !inflight && (p0 != '0) && (s_cnt >= FL + 1);
                exp_done  = inflight && done_s;
                check("mul_start", 64'(o_mul_start), 64'(exp_grant));
                if (exp_grant) begin
                    w = pick(p0, m_ptr);
                    check("grant_x", 64'(o_mul_x), 64'(m_x[w]));
                    check("grant_y", 64'(o_mul_y), 64'(m_y[w]));
                    inflight = 1; owner = w; exp_gx = m_x[w]; exp_gy = m_y[w];
                end else if (inflight) begin
                    check("hold_x", 64'(o_mul_x), 64'(exp_gx));
                    check("hold_y", 64'(o_mul_y), 64'(exp_gy));
                end
                if (exp_done) begin
                    check("done_vec", 64'(o_done), 64'(1) << owner);
                    check("result", 64'(o_o), 64'(mul_ref(exp_gx, exp_gy)));
                    m_pend[owner] = 1'b0;
                    m_ptr = (owner + 1) % N;
                    inflight = 0;
                end else begin
                    check("no_done", 64'(o_done), 0);
                end
                for (int r = 0; r < N; r++) begin
                    if (st_s[r]) begin
                        if (p0[r]) m_err = 1'b1;
                        else begin
                            m_pend[r] = 1'b1;
                            m_x[r] = x_s[W*r +: W];
                            m_y[r] = y_s[W*r +: W];
                        end
                    end
                end
                check("err", 64'(o_err), 64'(m_err));
                check("busy", 64'(o_busy), 64'((m_pend != '0) || inflight));
            end
            // Multiplier stand-in: keeps running across reset so an aborted op still answers.
            i_mul_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    i_mul_done = 1'b1;
                    i_mul_o = mres;
                end
            end
            if (o_mul_start) begin
                mres = o_mul_x * o_mul_y;
                mcnt = mul_lat;
            end
        end
    end

    task automatic pulse(input logic [N-1:0] st, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1);
        @(negedge i_clk);
        i_start = st; i_x = {x1, x0}; i_y = {y1, y0};
        @(negedge i_clk);
        i_start = '0;
    endtask

    task automatic wait_done(output logic [N-1:0] d, output logic [W-1:0] o);
        bit got;
        got = 0; d = '0; o = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge i_clk); #1;
            if (o_done != '0) begin
                got = 1; d = o_done; o = o_o;
            end
        end
        if (!got) check("done_timeout", 64'(got), 1);
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int c = 0; c < 300 && !idle; c++) begin
            @(negedge i_clk);
            if (!o_busy) idle = 1;
        end
        if (!idle) check("drain_timeout", 64'(idle), 1);
    endtask

    initial begin : stim
        logic [N-1:0] d;
        logic [W-1:0] o;
        logic [N-1:0] order [10];
        int           dn;

        i_rst = 1'b1; i_start = '0; i_x = '0; i_y = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (FL + 2) @(negedge i_clk);

        // Single op: grant one cycle after capture, result passed through untouched
        pulse(2'b01, 32'h00000001, 32'hDEADBEEF, '0, '0);
        check("single_no_early_start", 64'(o_mul_start), 0);
        @(posedge i_clk); #1;
        check("single_start_latency", 64'(o_mul_start), 1);
        wait_done(d, o);
        check("single_done_vec", 64'(d), 64'(2'b01));
        check("single_result", 64'(o), 64'(32'hDEADBEEF));
        @(posedge i_clk); #1;
        check("single_busy_after", 64'(o_busy), 0);

        // Restart on done: r1 restarts in its own done cycle
        pulse(2'b10, '0, '0, 32'd6, 32'd7);
        wait_done(d, o);
        check("restart_first_vec", 64'(d), 64'(2'b10));
        check("restart_first_o", 64'(o), 64'd42);
        pulse(2'b10, '0, '0, 32'd8, 32'd9);
        wait_done(d, o);
        check("restart_second_vec", 64'(d), 64'(2'b10));
        check("restart_second_o", 64'(o), 64'd72);
        check("restart_no_err", 64'(o_err), 0);

        // Simultaneous pair with pointer at 0
        pulse(2'b11, 32'h1, 32'h11111111, 32'h1, 32'h22222222);
        wait_done(d, o);
        check("pairA_first_vec", 64'(d), 64'(2'b01));
        check("pairA_first_o", 64'(o), 64'(32'h11111111));
        wait_done(d, o);
        check("pairA_second_vec", 64'(d), 64'(2'b10));
        check("pairA_second_o", 64'(o), 64'(32'h22222222));

        // One r0 op moves the pointer to 1, so the next pair serves r1 first
        pulse(2'b01, 32'd2, 32'd3, '0, '0);
        wait_done(d, o);
        check("ptr_move_o", 64'(o), 64'd6);
        pulse(2'b11, 32'h1, 32'h44444444, 32'h1, 32'h55555555);
        wait_done(d, o);
        check("pairB_first_vec", 64'(d), 64'(2'b10));
        check("pairB_first_o", 64'(o), 64'(32'h55555555));
        wait_done(d, o);
        check("pairB_second_vec", 64'(d), 64'(2'b01));
        check("pairB_second_o", 64'(o), 64'(32'h44444444));

        // Fairness: every done immediately re-requests
        pulse(2'b11, $urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 10; i++) begin
            wait_done(d, o);
            order[i] = d;
            if (i < 9) pulse(d, $urandom, $urandom, $urandom, $urandom);
        end
        drain();
        check("fair_first_r1", 64'(order[0]), 64'(2'b10));
        for (int i = 1; i < 10; i++) check($sformatf("fair_alternate_%0d", i), 64'(order[i] != order[i-1]), 1);
        check("fair_no_err", 64'(o_err), 0);

        // Duplicate start while in flight
        pulse(2'b01, 32'd3, 32'd5, '0, '0);
        @(negedge i_clk);
        pulse(2'b01, 32'd7, 32'd9, '0, '0);
        wait_done(d, o);
        check("dup_done_vec", 64'(d), 64'(2'b01));
        check("dup_result_first_ops", 64'(o), 64'd15);
        check("dup_err_set", 64'(o_err), 1);
        drain();
        check("dup_err_sticky", 64'(o_err), 1);

        // Reset while waiting on the multiplier; its late done must not complete anything
        pulse(2'b10, '0, '0, 32'd10, 32'd11);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge i_clk); #1;
            if (o_done != '0) dn++;
        end
        check("rst_mid_no_done", 64'(dn), 0);
        check("rst_mid_err_clear", 64'(o_err), 0);
        pulse(2'b10, '0, '0, 32'd12, 32'd13);
        wait_done(d, o);
        check("rst_mid_new_vec", 64'(d), 64'(2'b10));
        check("rst_mid_new_o", 64'(o), 64'd156);

        // Random traffic with varying multiplier latency
        for (int it = 0; it < 400; it++) begin
            @(negedge i_clk);
            if ($urandom_range(0, 3) == 0) begin
                i_start = N'($urandom_range(1, 3));
                i_x = {$urandom, $urandom};
                i_y = {$urandom, $urandom};
            end else begin
                i_start = '0;
            end
            if ($urandom_range(0, 15) == 0) mul_lat = $urandom_range(1, 4);
        end
        @(negedge i_clk);
        i_start = '0;
        drain();
        check("final_pending_empty", 64'(m_pend), 0);
        check("final_busy", 64'(o_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
